ifetch_unit: RTL and testbench
==============================

IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 Parameter: DEPTH, 2, max instructions in flight (pending request + outstanding + queued); legal values 2 or 4.
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-004 pc_in  in  32  fetch address from the PC register.
REQ-005 pc_valid  in  1  pc_in is valid this cycle.
REQ-006 pc_ready  out  1  unit accepts pc_in this cycle.
REQ-007 flush  in  1  discards all queued and in-flight instructions.
REQ-008 imem_req  out  1  instruction-memory read request.
REQ-009 imem_addr  out  32  word-aligned read address.
REQ-010 imem_gnt  in  1  memory accepts the current request.
REQ-011 imem_rvalid  in  1  read data valid; responses return in request order.
REQ-012 imem_rdata  in  32  instruction word.
REQ-013 inst_valid  out  1  queue head is valid.
REQ-014 inst_ready  in  1  consumer takes the head this cycle.
REQ-015 inst_out  out  32  head instruction word.
REQ-016 inst_pc  out  32  PC of the head instruction.
REQ-017 inst_pc4  out  32  inst_pc + 4, modulo 2^32.

Function
REQ-018 Accept: PC accepted on an edge where pc_valid && pc_ready.
REQ-019 pc_ready = !flush && !imem_req && (queued + outstanding + discard) < DEPTH; combinational, never depends on pc_valid.
REQ-020 imem_req registered: rises on the edge after acceptance, with imem_addr = {pc_in[31:2],2'b00} and the full pc_in captured for the queue.
REQ-021 imem_req and imem_addr held stable until an edge with imem_gnt=1; imem_req then falls and outstanding increments; a request is never withdrawn, including on flush.
REQ-022 imem_rvalid with outstanding=0 and no pending discard: ignored, no state change.
REQ-023 Response with discard>0: discard decrements, data dropped; otherwise outstanding decrements and {imem_rdata, PC} written to the queue tail.
REQ-024 Queue is registered FIFO of DEPTH entries; data written at edge N is visible on inst_* in cycle N+1 (no bypass).
REQ-025 Pop on edge where inst_valid && inst_ready; simultaneous push and pop legal at any occupancy.
REQ-026 Queue overflow cannot occur given REQ-019; underflow (pop when empty) ignored.
REQ-027 Flush edge: queue emptied; discard += outstanding (+1 if imem_req high and not granted that edge, +1 if granted that edge); outstanding cleared; response arriving same edge counts against discard.
REQ-028 inst_valid low on the cycle after a flush edge, regardless of a same-cycle pop or push.
REQ-029 Minimum latency: accept at edge 0, imem_req cycle 1, gnt in cycle 1, rvalid in cycle 2, inst_valid cycle 3.
REQ-030 Counters (queued, outstanding, discard) each 0..DEPTH; width ceil(log2(DEPTH+1)).

Reset
REQ-031 On reset: imem_req=0, imem_addr=0, inst_valid=0, inst_out=0, inst_pc=0, inst_pc4=4, all counters 0, queue empty.
REQ-032 Reset mid-operation drops all in-flight state; late imem_rvalid after release ignored per REQ-022.
REQ-033 pc_ready=0 while reset is high; pc_ready=1 on the first cycle after release if flush=0.

Verification
REQ-034 Single fetch: pc_in=0x00400000, gnt in cycle 1, rvalid with 0x20080005 in cycle 2 -> cycle 3 inst_valid=1, inst_out=0x20080005, inst_pc=0x00400000, inst_pc4=0x00400004.
REQ-035 Back-pressure: inst_ready=0, DEPTH=2, two PCs 0x0,0x4 fetched -> pc_ready=0 with queue full; one pop -> pc_ready=1 next cycle; order preserved.
REQ-036 Flush in flight: request 0x8 granted, flush before rvalid -> response 0xDEADBEEF dropped, inst_valid stays 0, next PC 0x100 returns normally.
REQ-037 Flush with ungranted request: gnt held low 3 cycles, flush in cycle 1 -> imem_req held until granted, its response dropped, discard returns to 0.
REQ-038 Wrap: pc_in=0xFFFFFFFC -> inst_pc4=0x00000000; pc_in=0x00000013 -> imem_addr=0x00000010, inst_pc=0x00000013.
REQ-039 Async reset asserted between gnt and rvalid -> outputs at reset values immediately; stray rvalid after release leaves inst_valid=0.

Source files
------------

// File: rtl/ifetch_unit.sv
// Instruction fetch: PC -> one-deep registered request -> in-order responses -> registered queue.
// Accept-to-inst_valid is at least 3 cycles; pc_ready stalls on a pending request or when in-flight plus queued plus discarded entries reach DEPTH.
module ifetch_unit #(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_in,
    input  logic        pc_valid,
    output logic        pc_ready,
    input  logic        flush,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_out,
    output logic [31:0] inst_pc,
    output logic [31:0] inst_pc4
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    logic          req_q, req_d;
    logic          doomed_q, doomed_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   req_pc_q, req_pc_d;
    logic [31:0]   opc_q [DEPTH];
    logic [PW-1:0] o_rd_q, o_rd_d, o_wr_q, o_wr_d;
    logic [CW-1:0] o_cnt_q, o_cnt_d;
    logic [CW-1:0] disc_q, disc_d;
    logic [31:0]   qd_q [DEPTH];
    logic [31:0]   qp_q [DEPTH];
    logic [PW-1:0] q_rd_q, q_rd_d, q_wr_q, q_wr_d;
    logic [CW-1:0] q_cnt_q, q_cnt_d;

    logic          accept, gnt, pop, resp_any, resp_drop, resp_take, push, opush;
    logic [CW+1:0] occ;
    logic [CW+1:0] disc_sum;

    always_comb begin
        occ       = (CW+2)'(q_cnt_q) + (CW+2)'(o_cnt_q) + (CW+2)'(disc_q);
        pc_ready  = !reset && !flush && !req_q && (occ < (CW+2)'(DEPTH));
        accept    = pc_valid && pc_ready;
        gnt       = req_q && imem_gnt;
        pop       = (q_cnt_q != '0) && inst_ready;
        resp_any  = imem_rvalid && ((disc_q != '0) || (o_cnt_q != '0));
        resp_drop = imem_rvalid && (disc_q != '0);
        resp_take = imem_rvalid && (disc_q == '0) && (o_cnt_q != '0);
        push      = resp_take && !flush;
        // A request already charged to discard by an earlier flush never becomes outstanding.
        opush     = gnt && !doomed_q && !flush;
        disc_sum  = (CW+2)'(disc_q) + (CW+2)'(o_cnt_q) + (CW+2)'(req_q && !doomed_q)
                    - (CW+2)'(resp_any);
    end

    always_comb begin
        req_d    = req_q;
        doomed_d = doomed_q;
        addr_d   = addr_q;
        req_pc_d = req_pc_q;
        o_rd_d   = o_rd_q;
        o_wr_d   = o_wr_q;
        o_cnt_d  = o_cnt_q;
        disc_d   = disc_q;
        q_rd_d   = q_rd_q;
        q_wr_d   = q_wr_q;
        q_cnt_d  = q_cnt_q;

        if (gnt) begin
            req_d    = 1'b0;
            doomed_d = 1'b0;
        end
        if (accept) begin
            req_d    = 1'b1;
            addr_d   = {pc_in[31:2], 2'b00};
            req_pc_d = pc_in;
        end

        if (flush) begin
            disc_d  = disc_sum[CW-1:0];
            o_rd_d  = '0;
            o_wr_d  = '0;
            o_cnt_d = '0;
            q_rd_d  = '0;
            q_wr_d  = '0;
            q_cnt_d = '0;
            if (req_q && !gnt) begin
                doomed_d = 1'b1;
            end
        end else begin
            if (resp_drop) begin
                disc_d = disc_q - CW'(1);
            end
            if (opush) begin
                o_wr_d = o_wr_q + PW'(1);
            end
            if (resp_take) begin
                o_rd_d = o_rd_q + PW'(1);
            end
            o_cnt_d = o_cnt_q + CW'(opush) - CW'(resp_take);
            if (pop) begin
                q_rd_d = q_rd_q + PW'(1);
            end
            if (push) begin
                q_wr_d = q_wr_q + PW'(1);
            end
            q_cnt_d = q_cnt_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_q    <= 1'b0;
            doomed_q <= 1'b0;
            addr_q   <= '0;
            req_pc_q <= '0;
            o_rd_q   <= '0;
            o_wr_q   <= '0;
            o_cnt_q  <= '0;
            disc_q   <= '0;
            q_rd_q   <= '0;
            q_wr_q   <= '0;
            q_cnt_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                opc_q[i] <= '0;
                qd_q[i]  <= '0;
                qp_q[i]  <= '0;
            end
        end else begin
            req_q    <= req_d;
            doomed_q <= doomed_d;
            addr_q   <= addr_d;
            req_pc_q <= req_pc_d;
            o_rd_q   <= o_rd_d;
            o_wr_q   <= o_wr_d;
            o_cnt_q  <= o_cnt_d;
            disc_q   <= disc_d;
            q_rd_q   <= q_rd_d;
            q_wr_q   <= q_wr_d;
            q_cnt_q  <= q_cnt_d;
            if (opush) begin
                opc_q[o_wr_q] <= req_pc_q;
            end
            if (push) begin
                qd_q[q_wr_q] <= imem_rdata;
                qp_q[q_wr_q] <= opc_q[o_rd_q];
            end
        end
    end

    assign imem_req   = req_q;
    assign imem_addr  = addr_q;
    assign inst_valid = (q_cnt_q != '0);
    assign inst_out   = qd_q[q_rd_q];
    assign inst_pc    = qp_q[q_rd_q];
    assign inst_pc4   = inst_pc + 32'd4;

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit with a transaction-level reference model and literal spot checks.
module tb_ifetch_unit;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pc_in = '0;
    logic        pc_valid = 1'b0;
    logic        pc_ready;
    logic        flush = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
    logic [31:0] inst_pc4;

    int total = 0;
    int bad = 0;

    ifetch_unit #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .pc_in(pc_in), .pc_valid(pc_valid), .pc_ready(pc_ready),
        .flush(flush), .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .inst_valid(inst_valid),
        .inst_ready(inst_ready), .inst_out(inst_out), .inst_pc(inst_pc), .inst_pc4(inst_pc4)
    );

    always #5 clk = ~clk;

    // Reference model: every fetch is a transaction tagged dropped or not; a flush tags
    // everything still travelling, and responses retire transactions oldest first.
    typedef struct packed {
        logic        drop;
        logic [31:0] pc;
    } infl_t;

    infl_t       m_inf[$];
    logic [63:0] m_q[$];
    bit          m_req = 1'b0;
    bit          m_req_drop = 1'b0;
    logic [31:0] m_req_pc = '0;

    function automatic bit m_ready();
        return !flush && !m_req && ((m_q.size() + m_inf.size()) < DEPTH);
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_inf.delete();
            m_q.delete();
            m_req = 1'b0;
            m_req_drop = 1'b0;
        end else begin
            bit    acc, gnt, pop, got;
            infl_t e;
            acc = pc_valid && m_ready();
            gnt = m_req && imem_gnt;
            pop = (m_q.size() > 0) && inst_ready;
            got = 1'b0;
            e = '0;
            if (imem_rvalid && m_inf.size() > 0) begin
                e = m_inf.pop_front();
                got = !e.drop && !flush;
            end
            if (flush) begin
                m_q.delete();
                foreach (m_inf[i]) m_inf[i].drop = 1'b1;
                if (m_req) m_req_drop = 1'b1;
            end else begin
                if (pop) void'(m_q.pop_front());
                if (got) m_q.push_back({imem_rdata, e.pc});
            end
            if (gnt) begin
                m_inf.push_back('{drop: m_req_drop, pc: m_req_pc});
                m_req = 1'b0;
            end
            if (acc) begin
                m_req = 1'b1;
                m_req_pc = pc_in;
                m_req_drop = 1'b0;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            chk("pc_ready", 32'(pc_ready), 32'(m_ready()));
            chk("imem_req", 32'(imem_req), 32'(m_req));
            if (m_req) chk("imem_addr", imem_addr, {m_req_pc[31:2], 2'b00});
            chk("inst_valid", 32'(inst_valid), 32'(m_q.size() > 0));
            if (m_q.size() > 0) begin
                chk("inst_out", inst_out, m_q[0][63:32]);
                chk("inst_pc", inst_pc, m_q[0][31:0]);
                chk("inst_pc4", inst_pc4, m_q[0][31:0] + 32'd4);
            end
        end
    end

    // One cycle of inputs: pc_valid, pc_in, gnt, rvalid, rdata, flush, inst_ready.
    task automatic drv(input logic pv, input logic [31:0] pc, input logic g, input logic rv,
                       input logic [31:0] rd, input logic fl, input logic ir);
        pc_valid = pv;
        pc_in = pc;
        imem_gnt = g;
        imem_rvalid = rv;
        imem_rdata = rd;
        flush = fl;
        inst_ready = ir;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic ir);
        drv(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, ir);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        #3;
        chk("rst_imem_req", 32'(imem_req), 32'h0);
        chk("rst_imem_addr", imem_addr, 32'h0);
        chk("rst_inst_valid", 32'(inst_valid), 32'h0);
        chk("rst_inst_out", inst_out, 32'h0);
        chk("rst_inst_pc", inst_pc, 32'h0);
        chk("rst_inst_pc4", inst_pc4, 32'h4);
        chk("rst_pc_ready", 32'(pc_ready), 32'h0);
        #9 reset = 1'b0;
        #1 chk("rel_pc_ready", 32'(pc_ready), 32'h1);

        // Single fetch at minimum latency.
        drv(1, 32'h00400000, 0, 0, 0, 0, 0);
        chk("t1_req", 32'(imem_req), 32'h1);
        chk("t1_addr", imem_addr, 32'h00400000);
        drv(0, 0, 1, 0, 0, 0, 0);
        chk("t1_req_fall", 32'(imem_req), 32'h0);
        chk("t1_valid_early", 32'(inst_valid), 32'h0);
        drv(0, 0, 0, 1, 32'h20080005, 0, 0);
        chk("t1_valid", 32'(inst_valid), 32'h1);
        chk("t1_out", inst_out, 32'h20080005);
        chk("t1_pc", inst_pc, 32'h00400000);
        chk("t1_pc4", inst_pc4, 32'h00400004);
        idle(1);
        chk("t1_popped", 32'(inst_valid), 32'h0);

        // Back-pressure with a full queue.
        drv(1, 32'h0, 0, 0, 0, 0, 0);
        drv(0, 0, 1, 0, 0, 0, 0);
        chk("t2_ready_one_out", 32'(pc_ready), 32'h1);
        drv(1, 32'h4, 0, 1, 32'h000000A0, 0, 0);
        drv(0, 0, 1, 0, 0, 0, 0);
        chk("t2_ready_busy", 32'(pc_ready), 32'h0);
        drv(0, 0, 0, 1, 32'h000000A4, 0, 0);
        chk("t2_ready_full", 32'(pc_ready), 32'h0);
        chk("t2_head_pc", inst_pc, 32'h0);
        chk("t2_head_out", inst_out, 32'h000000A0);
        idle(1);
        chk("t2_ready_after_pop", 32'(pc_ready), 32'h1);
        chk("t2_second_pc", inst_pc, 32'h4);
        chk("t2_second_out", inst_out, 32'h000000A4);
        idle(1);
        chk("t2_empty", 32'(inst_valid), 32'h0);

        // Flush after grant, before response.
        drv(1, 32'h8, 0, 0, 0, 0, 0);
        drv(0, 0, 1, 0, 0, 0, 0);
        drv(0, 0, 0, 0, 0, 1, 0);
        drv(0, 0, 0, 1, 32'hDEADBEEF, 0, 0);
        chk("t3_dropped", 32'(inst_valid), 32'h0);
        idle(0);
        chk("t3_still_empty", 32'(inst_valid), 32'h0);
        chk("t3_ready", 32'(pc_ready), 32'h1);
        drv(1, 32'h100, 0, 0, 0, 0, 0);
        drv(0, 0, 1, 0, 0, 0, 0);
        drv(0, 0, 0, 1, 32'h12345678, 0, 0);
        chk("t3_next_valid", 32'(inst_valid), 32'h1);
        chk("t3_next_pc", inst_pc, 32'h100);
        chk("t3_next_out", inst_out, 32'h12345678);
        idle(1);

        // Flush while the request is still waiting for a grant.
        drv(1, 32'h20, 0, 0, 0, 0, 0);
        drv(0, 0, 0, 0, 0, 1, 0);
        chk("t4_req_held1", 32'(imem_req), 32'h1);
        chk("t4_addr_held", imem_addr, 32'h20);
        idle(0);
        chk("t4_req_held2", 32'(imem_req), 32'h1);
        idle(0);
        chk("t4_req_held3", 32'(imem_req), 32'h1);
        drv(0, 0, 1, 0, 0, 0, 0);
        chk("t4_req_granted", 32'(imem_req), 32'h0);
        drv(0, 0, 0, 1, 32'hBADBAD00, 0, 0);
        chk("t4_dropped", 32'(inst_valid), 32'h0);
        drv(1, 32'h40, 0, 0, 0, 0, 0);
        drv(0, 0, 1, 0, 0, 0, 0);
        drv(0, 0, 0, 1, 32'h0000AAAA, 0, 0);
        chk("t4_after_valid", 32'(inst_valid), 32'h1);
        chk("t4_after_pc", inst_pc, 32'h40);
        idle(1);

        // Address wrap and unaligned PC.
        drv(1, 32'hFFFFFFFC, 0, 0, 0, 0, 0);
        drv(0, 0, 1, 0, 0, 0, 0);
        drv(0, 0, 0, 1, 32'h11111111, 0, 0);
        chk("t5_wrap_pc4", inst_pc4, 32'h00000000);
        idle(1);
        drv(1, 32'h00000013, 0, 0, 0, 0, 0);
        chk("t5_aligned_addr", imem_addr, 32'h00000010);
        drv(0, 0, 1, 0, 0, 0, 0);
        drv(0, 0, 0, 1, 32'h13131313, 0, 0);
        chk("t5_full_pc", inst_pc, 32'h00000013);
        chk("t5_pc4", inst_pc4, 32'h00000017);
        idle(1);

        // Stray response, flush coinciding with a response, push and pop together.
        drv(0, 0, 0, 1, 32'h55555555, 0, 0);
        chk("t6_stray", 32'(inst_valid), 32'h0);
        drv(1, 32'h50, 0, 0, 0, 0, 0);
        drv(0, 0, 1, 0, 0, 0, 0);
        drv(0, 0, 0, 1, 32'h77777777, 1, 0);
        chk("t6_flush_resp", 32'(inst_valid), 32'h0);
        drv(1, 32'h54, 0, 0, 0, 0, 0);
        drv(0, 0, 1, 0, 0, 0, 0);
        drv(0, 0, 0, 1, 32'h88888888, 0, 0);
        chk("t6_next_out", inst_out, 32'h88888888);
        idle(1);
        drv(1, 32'h60, 0, 0, 0, 0, 0);
        drv(0, 0, 1, 0, 0, 0, 0);
        drv(1, 32'h64, 0, 1, 32'h0000600D, 0, 0);
        drv(0, 0, 1, 0, 0, 0, 0);
        drv(0, 0, 0, 1, 32'h0000640D, 0, 1);
        chk("t6_pushpop_pc", inst_pc, 32'h64);
        chk("t6_pushpop_out", inst_out, 32'h0000640D);
        idle(1);
        chk("t6_drained", 32'(inst_valid), 32'h0);

        // Asynchronous reset between grant and response.
        drv(1, 32'h1F0, 0, 0, 0, 0, 0);
        drv(0, 0, 1, 0, 0, 0, 0);
        drv(0, 0, 0, 1, 32'h00001F0D, 0, 0);
        drv(1, 32'h200, 0, 0, 0, 0, 0);
        drv(0, 0, 1, 0, 0, 0, 0);
        chk("t7_pre_valid", 32'(inst_valid), 32'h1);
        pc_valid = 1'b0;
        imem_gnt = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("t7_req", 32'(imem_req), 32'h0);
        chk("t7_valid", 32'(inst_valid), 32'h0);
        chk("t7_out", inst_out, 32'h0);
        chk("t7_pc", inst_pc, 32'h0);
        chk("t7_pc4", inst_pc4, 32'h4);
        chk("t7_ready", 32'(pc_ready), 32'h0);
        @(negedge clk);
        #1 reset = 1'b0;
        #1 chk("t7_ready_release", 32'(pc_ready), 32'h1);
        drv(0, 0, 0, 1, 32'h0000CAFE, 0, 0);
        chk("t7_stray_valid", 32'(inst_valid), 32'h0);
        idle(0);
        chk("t7_ready_after", 32'(pc_ready), 32'h1);
        idle(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
